// File: rtl/word_serial_comparator_pkg.sv
// Shared types for the word-serial magnitude comparator: FSM states,
// cascade-state struct and reset constants.
package cmp_pkg;

  localparam int WORD_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cascade state, ordered to match the {e,l,g} / {E,L,G} port convention
  typedef struct packed {
    logic e;
    logic l;
    logic g;
  } casc_t;

  localparam casc_t ACC_RST = '{e: 1'b1, l: 1'b0, g: 1'b0};
  localparam casc_t RES_RST = '{e: 1'b0, l: 1'b0, g: 1'b0};

endpackage

// File: rtl/word_serial_comparator_if.sv
// Beat and result signals between a word source and the comparator.
interface word_serial_comparator_if #(
  parameter int WORD_W = cmp_pkg::WORD_W_DEF
);
  logic              start;
  logic              e;
  logic              l;
  logic              g;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              E;
  logic              L;
  logic              G;

  modport master (
    output start, e, l, g, a_word, b_word, in_valid,
    input  in_ready, busy, done, E, L, G
  );

  modport slave (
    input  start, e, l, g, a_word, b_word, in_valid,
    output in_ready, busy, done, E, L, G
  );
endinterface

// File: rtl/word_serial_comparator_hex.sv
// Combinational cascadable magnitude comparator: a differing word decides,
// an equal word passes the incoming cascade state through.
module hex_comparator #(
  parameter int WORD_W = cmp_pkg::WORD_W_DEF
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              e,
  input  logic              l,
  input  logic              g,
  output logic              E,
  output logic              L,
  output logic              G
);
  always_comb begin
    E = e;
    L = l;
    G = g;
    if (a > b) begin
      E = 1'b0;
      L = 1'b0;
      G = 1'b1;
    end else if (a < b) begin
      E = 1'b0;
      L = 1'b1;
      G = 1'b0;
    end
  end
endmodule

// File: rtl/word_serial_comparator.sv
// Sequential WORD_W*N_WORDS-bit comparator: one word pair per accepted beat,
// LSW first, cascade state carried in a register between beats.
module word_serial_comparator
  import cmp_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int N_WORDS = 4
) (
  input logic                      clk,
  input logic                      rst,
  word_serial_comparator_if.slave  bus
);
  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  casc_t            acc, res, cmp_o;
  logic             rdy_q, busy_q, done_q;
  logic             load, acc_en, last;

  hex_comparator #(.WORD_W(WORD_W)) u_cmp (
    .a (bus.a_word),
    .b (bus.b_word),
    .e (acc.e),
    .l (acc.l),
    .g (acc.g),
    .E (cmp_o.e),
    .L (cmp_o.l),
    .G (cmp_o.g)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accept is gated by the registered ready so it can never run ahead of it
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    acc_en    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid && rdy_q) begin
          acc_en = 1'b1;
          if (cnt == CNT_LAST) begin
            last      = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rdy_q  <= (state_nxt == RUN);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= ACC_RST;
    end else if (load) begin
      cnt <= '0;
      acc <= '{e: bus.e, l: bus.l, g: bus.g};
    end else if (acc_en) begin
      cnt <= last ? cnt : cnt + CNT_W'(1);
      acc <= cmp_o;
    end
  end

  // Result holds across new starts; only a completion or reset changes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       res <= RES_RST;
    else if (last) res <= cmp_o;
  end

  assign bus.in_ready = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.E        = res.e;
  assign bus.L        = res.l;
  assign bus.G        = res.g;

endmodule

// File: tb/tb_word_serial_comparator.sv
// Directed-vector bench for word_serial_comparator (WORD_W=16, N_WORDS=4).
module tb_word_serial_comparator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  word_serial_comparator_if #(.WORD_W(16)) bus ();

  word_serial_comparator #(.WORD_W(16), .N_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a/b packed {w3,w2,w1,w0}; w0 is sent first. poke drives start while busy.
  task automatic run_cmp(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] elg, input int gap, input logic [2:0] exp,
                         input bit poke);
    @(negedge clk);
    bus.start = 1'b1;
    {bus.e, bus.l, bus.g} = elg;
    @(negedge clk);
    bus.start = 1'b0;
    {bus.e, bus.l, bus.g} = 3'b111;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.a_word   = a[16*i +: 16];
      bus.b_word   = b[16*i +: 16];
      bus.in_valid = 1'b1;
      bus.start    = poke;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.a_word   = 16'hDEAD;
      bus.b_word   = 16'h0000;
      if (i < 3) begin
        chk({tag, ".early_done"}, 32'(bus.done), 32'd0);
        for (int k = 0; k < gap; k++) begin
          bus.start = poke;
          @(negedge clk);
          bus.start = 1'b0;
          chk({tag, ".gap_done"}, 32'(bus.done), 32'd0);
          chk({tag, ".gap_rdy"}, 32'(bus.in_ready), 32'd1);
        end
      end
    end
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".elg"}, 32'({bus.E, bus.L, bus.G}), 32'(exp));
    chk({tag, ".rdy_done"}, 32'(bus.in_ready), 32'd0);
    bus.start = poke;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".done_off"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    chk({tag, ".hold"}, 32'({bus.E, bus.L, bus.G}), 32'(exp));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.e        = 1'b1;
    bus.l        = 1'b0;
    bus.g        = 1'b0;
    bus.a_word   = '0;
    bus.b_word   = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.elg", 32'({bus.E, bus.L, bus.G}), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.rdy", 32'(bus.in_ready), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // a valid word in IDLE must not be consumed
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle.busy", 32'(bus.busy), 32'd0);

    run_cmp("eq0",   64'h0, 64'h0, 3'b100, 0, 3'b100, 1'b0);
    run_cmp("eqF",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 0, 3'b100, 1'b0);
    run_cmp("lswG",  64'h1234_5678_9ABC_0001, 64'h1234_5678_9ABC_0000, 3'b100, 0, 3'b001, 1'b0);
    run_cmp("lswL",  64'h1234_5678_9ABC_0000, 64'h1234_5678_9ABC_0001, 3'b100, 0, 3'b010, 1'b0);
    run_cmp("mswG",  64'h8000_0000_0000_0000, 64'h0000_0000_0000_FFFF, 3'b100, 0, 3'b001, 1'b0);
    run_cmp("mswL",  64'h0000_0000_0000_FFFF, 64'h8000_0000_0000_0000, 3'b100, 0, 3'b010, 1'b0);
    run_cmp("cascL", 64'hAAAA_5555_0F0F_F0F0, 64'hAAAA_5555_0F0F_F0F0, 3'b010, 0, 3'b010, 1'b0);
    run_cmp("cascG", 64'hFFFF_0000_0000_0000, 64'hFFFE_0000_0000_0000, 3'b010, 0, 3'b001, 1'b0);
    run_cmp("odd",   64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 3'b101, 0, 3'b101, 1'b0);
    run_cmp("gap",   64'h8000_0000_0000_0000, 64'h0000_0000_0000_FFFF, 3'b100, 3, 3'b001, 1'b1);
    run_cmp("midL",  64'h0000_0001_FFFF_FFFF, 64'h0000_0002_0000_0000, 3'b100, 1, 3'b010, 1'b1);

    // Reset after two beats discards the partial comparison
    @(negedge clk);
    bus.start = 1'b1;
    {bus.e, bus.l, bus.g} = 3'b100;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.a_word   = 16'h0005;
      bus.b_word   = 16'h0003;
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst.elg", 32'({bus.E, bus.L, bus.G}), 32'd0);
    chk("mrst.busy", 32'(bus.busy), 32'd0);
    chk("mrst.rdy", 32'(bus.in_ready), 32'd0);
    chk("mrst.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp("fresh", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 3'b100, 0, 3'b001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule
